// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU command framing logic.
// Contents: default widths, opcode encodings, FSM state encoding, opcode validity check.
package uart_alu_pkg;

  localparam int unsigned DBIT_DEF  = 8;
  localparam int unsigned NB_OP_DEF = 6;

  // ALU opcodes (low NB_OP bits of the third frame byte)
  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

  // Framing FSM state encoding
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_WAIT_A  = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_B  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_OP = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC    = 3'd3;
  localparam logic [ST_W-1:0] ST_SEND    = 3'd4;
  localparam logic [ST_W-1:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [ST_W-1:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_e;

  // True when the opcode is one the ALU implements
  function automatic logic is_valid_op(input logic [NB_OP_DEF-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_frame_timeout.sv
// Inter-byte timeout: counts s_tick pulses and flags expiry on the last allowed tick.
// Ports: clk, rst_n (async, active-low), clr_i (hold counter at zero),
//        tick_i (count enable pulse), expire_c (combinational expiry pulse).
module alu_frame_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority, so a byte arriving on the final tick suppresses expiry
  assign expire_c = tick_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_TICKS - 1));

  // Counter wraps to zero on expiry so the next frame starts fresh
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_c) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects a 3-byte command frame (A, B, opcode) from the UART receiver, presents the
// registered operands to the ALU, captures the result and hands it to the transmitter.
// Ports: clk, reset (async, active-low), s_tick, rx_done_tick, rx_dout, alu_result,
//        tx_done_tick in; op_a, op_b, op_code, tx_start, tx_din, busy, err_tick out.
module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int unsigned DBIT          = DBIT_DEF,
  parameter int unsigned NB_OP         = NB_OP_DEF,
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_dout,
  input  logic [DBIT-1:0]  alu_result,
  input  logic             tx_done_tick,
  output logic [DBIT-1:0]  op_a,
  output logic [DBIT-1:0]  op_b,
  output logic [NB_OP-1:0] op_code,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_din,
  output logic             busy,
  output logic             err_tick
);

  state_e           state_q;
  logic [DBIT-1:0]  op_a_q, op_b_q, tx_din_q;
  logic [NB_OP-1:0] op_code_q;
  logic             tx_start_q, busy_q, err_tick_q;
  logic             tmo_clr_c, tmo_expire_c, op_ok_c;

  // Counter only runs while a frame is partially received
  assign tmo_clr_c = rx_done_tick || !((state_q == WAIT_B) || (state_q == WAIT_OP));
  assign op_ok_c   = is_valid_op(NB_OP_DEF'(rx_dout[NB_OP-1:0]));

  alu_frame_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (tmo_clr_c),
    .tick_i  (s_tick),
    .expire_c(tmo_expire_c)
  );

  // Framing FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_code_q  <= '0;
      tx_din_q   <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_tick_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      err_tick_q <= 1'b0;
      case (state_q)
        WAIT_A: begin
          if (rx_done_tick) begin
            op_a_q  <= rx_dout;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done_tick) begin
            op_b_q  <= rx_dout;
            state_q <= WAIT_OP;
          end else if (tmo_expire_c) begin
            err_tick_q <= 1'b1;
            state_q    <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (rx_done_tick) begin
            if (op_ok_c) begin
              op_code_q <= rx_dout[NB_OP-1:0];
              busy_q    <= 1'b1;
              state_q   <= EXEC;
            end else begin
              err_tick_q <= 1'b1;
              state_q    <= WAIT_A;
            end
          end else if (tmo_expire_c) begin
            err_tick_q <= 1'b1;
            state_q    <= WAIT_A;
          end
        end
        EXEC: begin
          tx_din_q   <= alu_result;
          tx_start_q <= 1'b1;
          err_tick_q <= rx_done_tick;
          state_q    <= SEND;
        end
        SEND: begin
          err_tick_q <= rx_done_tick;
          state_q    <= WAIT_TX;
        end
        WAIT_TX: begin
          err_tick_q <= rx_done_tick;
          if (tx_done_tick) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_A;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_code  = op_code_q;
  assign tx_din   = tx_din_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign err_tick = err_tick_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: directed frames, timeout, overrun and reset cases.
module tb_uart_alu_interface;

  localparam int unsigned TO     = 16;
  localparam int unsigned TX_LAT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic [7:0] alu_result;
  logic [7:0] op_a, op_b, tx_din;
  logic [5:0] op_code;
  logic       tx_start, busy, err_tick;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  uart_alu_interface #(
    .DBIT(8),
    .NB_OP(6),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_dout     (rx_dout),
    .alu_result  (alu_result),
    .tx_done_tick(tx_done_tick),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_code     (op_code),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .busy        (busy),
    .err_tick    (err_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Environment ALU driven from the DUT's registered operands
  always_comb begin
    case (op_code)
      6'b100000: alu_result = op_a + op_b;
      6'b100010: alu_result = op_a - op_b;
      6'b100100: alu_result = op_a & op_b;
      6'b100101: alu_result = op_a | op_b;
      6'b100110: alu_result = op_a ^ op_b;
      6'b100111: alu_result = ~(op_a | op_b);
      6'b000011: alu_result = $signed(op_a) >>> op_b;
      6'b000010: alu_result = op_a >> op_b;
      default:   alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the oldest expected event of the given kind and compares it
  task automatic sb_pop(input bit is_err, input logic [7:0] data);
    int idx;
    idx = -1;
    foreach (sb[i]) begin
      if (idx < 0 && sb[i].is_err == is_err) idx = i;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d expected none",
               is_err ? "err_tick" : "tx_start", cyc);
    end else begin
      check(is_err ? "err_tick_cycle" : "tx_start_cycle", cyc, sb[idx].cyc);
      if (!is_err) check("tx_din", 32'(data), 32'(sb[idx].data));
      sb.delete(idx);
    end
  endtask

  // Monitor: every output pulse must match a queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (tx_start === 1'b1) sb_pop(1'b0, tx_din);
        if (err_tick === 1'b1) sb_pop(1'b1, 8'h00);
      end
    end
  end

  // Transmitter model: completes a frame TX_LAT cycles after tx_start
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && reset === 1'b1) begin
        repeat (TX_LAT - 1) @(negedge clk);
        check("busy_before_tx_done", 32'(busy), 32'd1);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
      end
    end
  end

  // kind: 0 = no event, 1 = tx_start with exp_data, 2 = err_tick
  task automatic send_byte(input logic [7:0] b, input bit tick, input int kind,
                           input logic [7:0] exp_data);
    @(negedge clk);
    rx_dout      = b;
    rx_done_tick = 1'b1;
    s_tick       = tick;
    if (kind == 1) sb.push_back('{1'b0, exp_data, cyc + 32'd2});
    else if (kind == 2) sb.push_back('{1'b1, 8'h00, cyc + 32'd1});
    @(negedge clk);
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
  endtask

  task automatic pulse_tick(input bit expect_err);
    @(negedge clk);
    s_tick = 1'b1;
    if (expect_err) sb.push_back('{1'b1, 8'h00, cyc + 32'd1});
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp);
    send_byte(a, 1'b0, 0, 8'h00);
    send_byte(b, 1'b0, 0, 8'h00);
    send_byte(op, 1'b0, 1, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_bound", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_op_a", 32'(op_a), 32'h00);
    check("rst_outputs", 32'({tx_start, busy, err_tick}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ADD frame
    send_frame(8'h05, 8'h03, 8'h20, 8'h08);
    check("add_op_a", 32'(op_a), 32'h05);
    check("add_op_b", 32'(op_b), 32'h03);
    check("add_op_code", 32'(op_code), 32'h20);
    check("add_busy", 32'(busy), 32'd1);
    wait_idle();
    check("add_tx_din_held", 32'(tx_din), 32'h08);

    // Invalid opcode, then a good SRA frame
    send_byte(8'h0F, 1'b0, 0, 8'h00);
    send_byte(8'h01, 1'b0, 0, 8'h00);
    send_byte(8'h3F, 1'b0, 2, 8'h00);
    check("badop_op_code_kept", 32'(op_code), 32'h20);
    check("badop_not_busy", 32'(busy), 32'd0);
    send_frame(8'hF0, 8'h02, 8'h03, 8'hFC);
    check("sra_op_code", 32'(op_code), 32'h03);
    wait_idle();

    // Timeout after byte A
    send_byte(8'h11, 1'b0, 0, 8'h00);
    for (int i = 0; i < int'(TO) - 1; i++) pulse_tick(1'b0);
    pulse_tick(1'b1);
    check("tmo_not_busy", 32'(busy), 32'd0);
    send_frame(8'h22, 8'h01, 8'h22, 8'h21);
    check("tmo_new_op_a", 32'(op_a), 32'h22);
    wait_idle();

    // Byte B on the expiry tick wins; counter restarts
    send_byte(8'h40, 1'b0, 0, 8'h00);
    for (int i = 0; i < int'(TO) - 1; i++) pulse_tick(1'b0);
    send_byte(8'h44, 1'b1, 0, 8'h00);
    check("coinc_op_b", 32'(op_b), 32'h44);
    for (int i = 0; i < int'(TO) - 1; i++) pulse_tick(1'b0);
    send_byte(8'h24, 1'b0, 1, 8'h40);
    wait_idle();

    // Overrun during WAIT_TX
    send_frame(8'h07, 8'h05, 8'h26, 8'h02);
    repeat (4) @(negedge clk);
    send_byte(8'h99, 1'b0, 2, 8'h00);
    check("ovr_tx_din", 32'(tx_din), 32'h02);
    check("ovr_op_a", 32'(op_a), 32'h07);
    wait_idle();
    send_frame(8'h0C, 8'h03, 8'h25, 8'h0F);
    wait_idle();

    // Reset while waiting for the opcode
    send_byte(8'h12, 1'b0, 0, 8'h00);
    send_byte(8'h34, 1'b0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ops", 32'({op_a, op_b, 2'b00, op_code}), 32'd0);
    check("midrst_tx_din", 32'(tx_din), 32'h00);
    check("midrst_flags", 32'({tx_start, busy, err_tick}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send_frame(8'h0A, 8'h03, 8'h02, 8'h01);
    wait_idle();
    check("post_rst_tx_din", 32'(tx_din), 32'h01);

    // NOR with upper opcode-byte bits set
    send_frame(8'h0F, 8'h30, 8'hE7, 8'hC0);
    check("nor_op_code", 32'(op_code), 32'h27);
    wait_idle();

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
Sits directly downstream of the UART receiver and upstream of the UART transmitter in the UART-ALU top level. Collects a 3-byte command frame (operand A, operand B, opcode), drives the registered operands/opcode to the combinational ALU, captures the result and hands it to the transmitter with a start/done handshake. Includes an inter-byte timeout, based on the shared oversampling tick, that resynchronises framing after a partial frame.

Parameters:
DBIT, 8, data/operand/result width in bits (equals UART data width)
NB_OP, 6, opcode width in bits (low NB_OP bits of the third byte)
TIMEOUT_TICKS, 1024, s_tick count allowed between bytes of one frame before the partial frame is discarded (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
s_tick  in  1  oversampling tick from the baud generator, 1-cycle pulse
rx_done_tick  in  1  receiver byte-complete pulse, 1 cycle
rx_dout  in  DBIT  received byte, valid when rx_done_tick=1
alu_result  in  DBIT  combinational ALU result for op_a/op_b/op_code
tx_done_tick  in  1  transmitter frame-complete pulse
op_a  out  DBIT  registered operand A
op_b  out  DBIT  registered operand B
op_code  out  NB_OP  registered opcode
tx_start  out  1  1-cycle pulse requesting transmission of tx_din
tx_din  out  DBIT  registered byte to transmit
busy  out  1  high in EXEC, SEND, WAIT_TX
err_tick  out  1  1-cycle pulse: invalid opcode, timeout or overrun

Behaviour:
- Reset (reset=0, async): state=WAIT_A; op_a, op_b, op_code, tx_din, timeout counter = 0; tx_start=busy=err_tick=0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on rx_done_tick, op_a<=rx_dout, clear timeout counter, go WAIT_B.
- WAIT_B: on rx_done_tick, op_b<=rx_dout, clear counter, go WAIT_OP.
- WAIT_OP: on rx_done_tick, if rx_dout[NB_OP-1:0] is valid, op_code<=it, go EXEC; otherwise err_tick=1, go WAIT_A (op_a/op_b keep old values). Bits above NB_OP are ignored.
- Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010. These are defined in the shared package.
- Timeout (WAIT_B, WAIT_OP only): counter increments on s_tick. On the s_tick where counter==TIMEOUT_TICKS-1 with no rx_done_tick in the same cycle: err_tick=1, go WAIT_A, counter cleared. rx_done_tick in the same cycle wins.
- Counter is held at 0 in all other states.
- EXEC (exactly 1 cycle): tx_din<=alu_result, go SEND. op_a/op_b/op_code are stable from the cycle after the opcode byte through WAIT_TX.
- SEND (1 cycle): tx_start=1, go WAIT_TX.
- WAIT_TX: on tx_done_tick, go WAIT_A. tx_done_tick in any other state is ignored.
- Overrun: rx_done_tick in EXEC, SEND or WAIT_TX causes err_tick=1. The byte is dropped and the state is unaffected.
- Latency: opcode rx_done_tick at cycle N -> tx_start at N+2.
- Outputs tx_start, err_tick and busy are decoded from the current state and event (Moore/Mealy). err_tick is high for at most 1 cycle per event.
- Reset asserted mid-frame or mid-transmit aborts immediately. After release, the block waits for a fresh byte A.

Decomposition:
- Package uart_alu_pkg holds: opcode localparams (OP_ADD … OP_SRL), NB_OP default, state encoding localparams, and an is_valid_op function.
- Natural sub-module: alu_frame_timeout, the s_tick counter with clear/enable and an expire pulse. The FSM stays in uart_alu_interface.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with alu_result tied to 0x08 -> op_a=0x05, op_b=0x03, op_code=6'b100000; tx_start 2 cycles after third rx_done_tick; tx_din=0x08; busy until tx_done_tick.
- Bytes 0x0F, 0x01, 0x3F (invalid) -> err_tick one pulse, no tx_start; next frame 0xF0, 0x02, 0x03 completes normally with op_code=6'b000011.
- Byte 0x11, then TIMEOUT_TICKS s_ticks with no byte -> err_tick on the last tick, state WAIT_A; next byte 0x22 is latched as op_a.
- Timeout expiry tick coincident with rx_done_tick of byte B=0x44 -> no err_tick; op_b=0x44; state WAIT_OP.
- Extra rx_done_tick (0x99) during WAIT_TX -> err_tick pulse; tx_din unchanged; op_a unchanged; the following frame completes.
- reset=0 pulse while in WAIT_OP -> all outputs 0, state WAIT_A; a subsequent full frame produces correct tx_din.
